// File: rtl/shiftreg_frame_serializer_pkg.sv
// Shared types for the frame serializer: FSM state encoding and counter sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package shiftreg_pkg;

  // PAR is only reachable when SHIFTREG_PARITY_EN is defined.
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STAT,
    DYN,
    PAR,
    LATCH
  } state_t;

  // Bit counter width: wide enough to count the longer of the two segments.
  function automatic int cnt_w(input int size_a, input int size_b);
    return $clog2(((size_a > size_b) ? size_a : size_b) + 1);
  endfunction

endpackage

// File: rtl/shiftreg_frame_serializer_if.sv
// Dynamic-word handshake between the register interface and the serializer.
// Latency: n/a (wires only).
// Backpressure: producer holds dyn_valid/dyn_word until dyn_ready is seen high.
interface shiftreg_frame_serializer_if #(
  parameter int SIZE_DYN = 16
) ();

  logic                dyn_valid;
  logic [SIZE_DYN-1:0] dyn_word;
  logic                dyn_ready;

  modport master (
    output dyn_valid,
    output dyn_word,
    input  dyn_ready
  );

  modport slave (
    input  dyn_valid,
    input  dyn_word,
    output dyn_ready
  );

endinterface

// File: rtl/shiftreg_frame_serializer_bit_timer.sv
// Bit-period divider: down-counter reloaded at each bit start, bit_tick on the final cycle.
// Latency: bit_tick asserts div+1 cycles after a reload (immediately when div=0).
// Backpressure: none; reload always wins over counting.
module shiftreg_bit_timer #(
  parameter int DIV_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             reload,
  input  logic [DIV_W-1:0] div,
  output logic             bit_tick
);

  logic [DIV_W-1:0] cnt;

  // Reload on each bit start, otherwise count down and park at zero.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
    end else if (reload) begin
      cnt <= div;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign bit_tick = (cnt == '0);

endmodule

// File: rtl/shiftreg_frame_serializer.sv
// Frame serializer: static word, dynamic word, optional even parity (SHIFTREG_PARITY_EN) on ser_out.
// Latency: start at t -> first bit at t+2, latch_stb at t+2+frame_bits*(cfg_div+1).
// Backpressure: dyn_ready low while the one-entry buffer is full, except in LOAD where it drains.
module shiftreg_frame_serializer
  import shiftreg_pkg::*;
#(
  parameter int SIZE_STAT = 88,
  parameter int SIZE_DYN  = 16,
  parameter int DIV_W     = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DIV_W-1:0]      cfg_div,
  input  logic                  cfg_msb_first,
  input  logic                  cfg_continuous,
  input  logic                  start,
  input  logic [SIZE_STAT-1:0]  stat_word,
  shiftreg_frame_serializer_if.slave dyn_if,
  output logic                  ser_out,
  output logic                  sel_stat,
  output logic                  sel_dyn,
  output logic                  latch_stb,
  output logic                  frame_done,
  output logic                  busy,
  output logic                  underrun
);

  localparam int CNT_W = cnt_w(SIZE_STAT, SIZE_DYN);
`ifdef SHIFTREG_PARITY_EN
  localparam int FRAME_W = SIZE_STAT + SIZE_DYN + 1;
`else
  localparam int FRAME_W = SIZE_STAT + SIZE_DYN;
`endif
  localparam logic [CNT_W-1:0] STAT_LAST = CNT_W'(SIZE_STAT - 1);
  localparam logic [CNT_W-1:0] DYN_LAST  = CNT_W'(SIZE_DYN - 1);

  state_t               state;
  logic [FRAME_W-1:0]   shreg;
  logic [FRAME_W-1:0]   shreg_shift;
  logic [FRAME_W-1:0]   frame_nxt;
  logic [CNT_W-1:0]     bit_cnt;
  logic [DIV_W-1:0]     div_q;
  logic [SIZE_DYN-1:0]  dyn_buf;
  logic [SIZE_DYN-1:0]  dyn_last;
  logic [SIZE_DYN-1:0]  dyn_sel;
  logic [SIZE_DYN-1:0]  dyn_ord;
  logic [SIZE_STAT-1:0] stat_ord;
  logic                 dyn_full;
  logic                 dyn_xfer;
  logic                 in_bit;
  logic                 bit_tick;
  logic                 tmr_reload;
  logic [DIV_W-1:0]     tmr_div;

  assign dyn_if.dyn_ready = !dyn_full || (state == LOAD);
  assign dyn_xfer         = dyn_if.dyn_valid && dyn_if.dyn_ready;

  assign in_bit      = (state == STAT) || (state == DYN) || (state == PAR);
  assign shreg_shift = {shreg[FRAME_W-2:0], 1'b0};

  // The divider value is live in LOAD (first bit) and frozen in div_q afterwards.
  assign tmr_reload = (state == LOAD) || (in_bit && bit_tick);
  assign tmr_div    = (state == LOAD) ? cfg_div : div_q;

  shiftreg_bit_timer #(
    .DIV_W (DIV_W)
  ) u_bit_timer (
    .CLK      (CLK),
    .RST      (RST),
    .reload   (tmr_reload),
    .div      (tmr_div),
    .bit_tick (bit_tick)
  );

  // Build the frame in transmission order (MSB of frame_nxt goes out first).
  always_comb begin
    dyn_sel  = dyn_full ? dyn_buf : dyn_last;
    stat_ord = stat_word;
    dyn_ord  = dyn_sel;
    if (!cfg_msb_first) begin
      for (int i = 0; i < SIZE_STAT; i++) stat_ord[SIZE_STAT-1-i] = stat_word[i];
      for (int i = 0; i < SIZE_DYN; i++)  dyn_ord[SIZE_DYN-1-i]   = dyn_sel[i];
    end
`ifdef SHIFTREG_PARITY_EN
    frame_nxt = {stat_ord, dyn_ord, ^{stat_word, dyn_sel}};
`else
    frame_nxt = {stat_ord, dyn_ord};
`endif
  end

  // Holding buffer: a handshake fills it, LOAD drains it; a same-cycle refill wins.
  always_ff @(posedge CLK) begin
    if (RST) begin
      dyn_full <= 1'b0;
      dyn_buf  <= '0;
    end else if (dyn_xfer) begin
      dyn_full <= 1'b1;
      dyn_buf  <= dyn_if.dyn_word;
    end else if (state == LOAD) begin
      dyn_full <= 1'b0;
    end
  end

  // Frame sequencer: state, shift register, bit counter and registered strobes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      div_q      <= '0;
      dyn_last   <= '0;
      ser_out    <= 1'b0;
      sel_stat   <= 1'b0;
      sel_dyn    <= 1'b0;
      latch_stb  <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      latch_stb  <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            busy  <= 1'b1;
            if (dyn_full) underrun <= 1'b0;
          end
        end
        LOAD: begin
          div_q    <= cfg_div;
          shreg    <= frame_nxt;
          ser_out  <= frame_nxt[FRAME_W-1];
          sel_stat <= 1'b1;
          bit_cnt  <= '0;
          dyn_last <= dyn_sel;
          if (!dyn_full) underrun <= 1'b1;
          state    <= STAT;
        end
        STAT: begin
          if (bit_tick) begin
            shreg   <= shreg_shift;
            ser_out <= shreg[FRAME_W-2];
            if (bit_cnt == STAT_LAST) begin
              bit_cnt  <= '0;
              sel_stat <= 1'b0;
              sel_dyn  <= 1'b1;
              state    <= DYN;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        DYN: begin
          if (bit_tick) begin
            if (bit_cnt == DYN_LAST) begin
              bit_cnt <= '0;
              sel_dyn <= 1'b0;
`ifdef SHIFTREG_PARITY_EN
              shreg   <= shreg_shift;
              ser_out <= shreg[FRAME_W-2];
              state   <= PAR;
`else
              ser_out    <= 1'b0;
              latch_stb  <= 1'b1;
              frame_done <= 1'b1;
              state      <= LATCH;
`endif
            end else begin
              shreg   <= shreg_shift;
              ser_out <= shreg[FRAME_W-2];
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        PAR: begin
          if (bit_tick) begin
            ser_out    <= 1'b0;
            latch_stb  <= 1'b1;
            frame_done <= 1'b1;
            state      <= LATCH;
          end
        end
        LATCH: begin
          if (cfg_continuous) begin
            state <= LOAD;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/shiftreg_frame_serializer.md
Name: shiftreg_frame_serializer

Overview:
Parametrised successor of the static/dynamic shift-register generator path. It serializes one frame per trigger: a static word, then a dynamic word, then an optional parity bit, on a single serial line. Bit rate is programmable and bit order is selectable. The dynamic word arrives through a valid/ready handshake into a single-entry holding buffer, and frames can repeat continuously. It sits between the uC-facing register interface and the signal generator and replaces the fixed FSM. Its sel/latch strobes drive the generator's DYNLATCH/STATLATCH capture.

Parameters:
SIZE_STAT, 88, static word length in bits (>=1)
SIZE_DYN, 16, dynamic word length in bits (>=1)
DIV_W, 8, width of the bit-period divider config

Ports:
CLK  in  1  system clock
RST  in  1  synchronous reset, active-high
cfg_div  in  DIV_W  bit period = cfg_div+1 CLK cycles
cfg_msb_first  in  1  1: MSB first per word; 0: LSB first
cfg_continuous  in  1  1: a new frame starts automatically after each frame
start  in  1  one-cycle trigger for a frame
stat_word  in  SIZE_STAT  static word, sampled at LOAD
dyn_valid  in  1  dynamic word offered
dyn_word  in  SIZE_DYN  dynamic word
dyn_ready  out  1  holding buffer can accept
ser_out  out  1  serial data
sel_stat  out  1  high while static bits are on ser_out
sel_dyn  out  1  high while dynamic bits are on ser_out
latch_stb  out  1  one-cycle pulse after the final bit
frame_done  out  1  one-cycle pulse, coincident with latch_stb
busy  out  1  high in every state except IDLE
underrun  out  1  sticky: a frame reused a stale dynamic word

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high.
- Reset: every output is 0 except dyn_ready, which is 1. Buffer is empty, last-used word is 0, FSM is in IDLE.
- RST asserted mid-frame: the frame is abandoned and all outputs return to reset values on the next edge. No latch_stb is issued.
- FSM states: IDLE, LOAD, STAT, DYN, [PAR], LATCH.
- IDLE -> LOAD: when start=1. Otherwise hold.
- LOAD (1 cycle):
  - Capture stat_word, cfg_div and cfg_msb_first.
  - If the buffer is full, take its word and empty the buffer.
  - If the buffer is empty, reuse the last-used dynamic word and set underrun.
  - Load the shift register. Next state is STAT.
- STAT: ser_out carries the current bit, held for cfg_div+1 cycles. sel_stat=1. After SIZE_STAT bits, go to DYN.
- DYN: same bit timing, sel_dyn=1. After SIZE_DYN bits, go to LATCH (or PAR when the optional feature is enabled).
- LATCH (1 cycle): latch_stb=1, frame_done=1, ser_out=0.
  - Next state is LOAD if cfg_continuous=1 (sampled in LATCH), else IDLE.
- Outside STAT/DYN/PAR: ser_out=0.
- start while busy=1 is ignored; it is not queued.
- Latency: start at cycle t -> first bit at t+2. latch_stb at t+2+(SIZE_STAT+SIZE_DYN)*(cfg_div+1).
- Handshake:
  - A transfer occurs when dyn_valid && dyn_ready. dyn_word is captured and the buffer becomes full.
  - dyn_ready = !full || (state==LOAD), so a new word is accepted in the same cycle LOAD drains the buffer.
  - A word accepted during a frame is used by the next frame.
- Divider: down-counter reloaded with cfg_div at each bit start. cfg_div=0 gives one bit per cycle. Changes to cfg_div mid-frame have no effect.
- Bit counter: width is $clog2(max(SIZE_STAT,SIZE_DYN)+1). It resets at each segment boundary.
- underrun: cleared only by RST or by a start pulse accepted in IDLE with the buffer full.

Optional Feature:
SHIFTREG_PARITY_EN:
- Defined: after DYN, a PAR state emits one bit of even parity over all SIZE_STAT+SIZE_DYN frame bits, for cfg_div+1 cycles, with sel_stat=sel_dyn=0. Frame length grows by one bit.
- Undefined: there is no PAR state, and DYN goes directly to LATCH.

Decomposition:
- Package shiftreg_pkg: the state enum type (IDLE, LOAD, STAT, DYN, PAR, LATCH) and a localparam helper for counter width.
- Sub-module shiftreg_bit_timer: the divider down-counter. Inputs are reload and div; output is a bit_tick pulse on the last cycle of each bit period.

Test Plan:
- SIZE_STAT=8, SIZE_DYN=4, cfg_div=0, MSB-first, stat=8'hA5, dyn=4'h3 (pre-loaded), start at t -> ser_out = 1,0,1,0,0,1,0,1,0,0,1,1 on t+2..t+13; sel_stat high on t+2..t+9, sel_dyn high on t+10..t+13; latch_stb=frame_done=1 at t+14 only.
- Same frame with cfg_msb_first=0 and cfg_div=2 -> bits 1,0,1,0,0,1,0,1,1,1,0,0, each held 3 cycles; latch_stb at t+38.
- cfg_continuous=1, no new dyn word after the first frame -> second LOAD immediately follows LATCH; the second frame repeats 4'h3; underrun=1 from the second LOAD onward.
- dyn_valid held high with the buffer full -> dyn_ready=0 until the LOAD cycle, where dyn_ready=1 and the new word is captured; dyn_ready=0 again on the next cycle.
- start pulsed at frame bit 5 -> no effect on ser_out, and only one latch_stb is produced. RST asserted at bit 7 -> next cycle busy=0, ser_out=0, dyn_ready=1, and no latch_stb.
- With SHIFTREG_PARITY_EN, stat=8'hA5 and dyn=4'h3 (six 1s) -> parity bit 0 appended at t+14; latch_stb at t+15.
